// File: rtl/ascon_aead_ctrl.sv
// rtl/ascon_aead_ctrl.sv - Ascon-128 encryption sequencer driving an external permutation engine
module ascon_aead_ctrl #(
    parameter logic [63:0] IV = 64'h80400C0600000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] nonce,
    input  logic         has_ad,
    input  logic         has_msg,
    input  logic         ad_valid,
    output logic         ad_ready,
    input  logic [63:0]  ad_data,
    input  logic         ad_last,
    input  logic [3:0]   ad_bytes,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [63:0]  msg_data,
    input  logic         msg_last,
    input  logic [3:0]   msg_bytes,
    output logic         ct_valid,
    output logic [63:0]  ct_data,
    output logic [3:0]   ct_bytes,
    output logic         ct_last,
    output logic [127:0] tag,
    output logic         tag_valid,
    output logic         busy,
    output logic [319:0] perm_state_in,
    output logic [3:0]   perm_rounds,
    output logic         perm_start,
    input  logic [319:0] perm_state_out,
    input  logic         perm_done
);

    typedef enum logic [3:0] {
        IDLE, INIT, AD_WAIT, AD_PERM, AD_PAD, DOMSEP,
        MSG_WAIT, MSG_PERM, MSG_PAD, FINAL, DONE
    } state_e;

    localparam logic [63:0] PAD_BIT = 64'h8000_0000_0000_0000;

    state_e         state_q, state_d;
    logic [319:0]   s_q, s_d;
    logic [127:0]   key_q, key_d;
    logic           has_ad_q, has_ad_d;
    logic           has_msg_q, has_msg_d;
    logic           last_q, last_d;
    logic           full_q, full_d;
    logic           perm_start_q, perm_start_d;
    logic [3:0]     perm_rounds_q, perm_rounds_d;
    logic           ct_valid_q, ct_valid_d;
    logic [63:0]    ct_data_q, ct_data_d;
    logic [3:0]     ct_bytes_q, ct_bytes_d;
    logic           ct_last_q, ct_last_d;
    logic [127:0]   tag_q, tag_d;
    logic           tag_valid_q, tag_valid_d;

    logic           go_final;
    logic [3:0]     n_ad, n_msg;
    logic [63:0]    x0_msg;

    // Byte count of a stream word: only a last word may be short; 0 or >8 means full.
    function automatic logic [3:0] eff_n(input logic [3:0] b, input logic last);
        return (!last || b == 4'd0 || b > 4'd8) ? 4'd8 : b;
    endfunction

    function automatic logic [63:0] keep_mask(input logic [3:0] n);
        return ~64'd0 << {4'd8 - n, 3'b000};
    endfunction

    function automatic logic [63:0] pad64(input logic [63:0] d, input logic [3:0] n);
        return (d & keep_mask(n)) |
               ((n == 4'd8) ? 64'd0 : (PAD_BIT >> {n[2:0], 3'b000}));
    endfunction

    assign n_ad   = eff_n(ad_bytes, ad_last);
    assign n_msg  = eff_n(msg_bytes, msg_last);
    assign x0_msg = s_q[319:256] ^ pad64(msg_data, n_msg);

    always_comb begin
        state_d       = state_q;
        s_d           = s_q;
        key_d         = key_q;
        has_ad_d      = has_ad_q;
        has_msg_d     = has_msg_q;
        last_d        = last_q;
        full_d        = full_q;
        perm_start_d  = 1'b0;
        perm_rounds_d = perm_rounds_q;
        ct_valid_d    = 1'b0;
        ct_data_d     = ct_data_q;
        ct_bytes_d    = ct_bytes_q;
        ct_last_d     = ct_last_q;
        tag_d         = tag_q;
        tag_valid_d   = 1'b0;
        go_final      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    s_d           = {IV, key, nonce};
                    key_d         = key;
                    has_ad_d      = has_ad;
                    has_msg_d     = has_msg;
                    perm_start_d  = 1'b1;
                    perm_rounds_d = 4'd12;
                    state_d       = INIT;
                end
            end
            INIT: begin
                if (perm_done) begin
                    s_d     = perm_state_out ^ {192'd0, key_q};
                    state_d = has_ad_q ? AD_WAIT : DOMSEP;
                end
            end
            AD_WAIT: begin
                if (ad_valid) begin
                    s_d[319:256]  = s_q[319:256] ^ pad64(ad_data, n_ad);
                    last_d        = ad_last;
                    full_d        = (n_ad == 4'd8);
                    perm_start_d  = 1'b1;
                    perm_rounds_d = 4'd6;
                    state_d       = AD_PERM;
                end
            end
            AD_PERM: begin
                if (perm_done) begin
                    s_d = perm_state_out;
                    if (!last_q) begin
                        state_d = AD_WAIT;
                    end else if (!full_q) begin
                        state_d = DOMSEP;
                    end else begin
                        // A full last AD word still needs an all-padding block.
                        s_d[319:256]  = perm_state_out[319:256] ^ PAD_BIT;
                        perm_start_d  = 1'b1;
                        perm_rounds_d = 4'd6;
                        state_d       = AD_PAD;
                    end
                end
            end
            AD_PAD: begin
                if (perm_done) begin
                    s_d     = perm_state_out;
                    state_d = DOMSEP;
                end
            end
            DOMSEP: begin
                s_d[0] = ~s_q[0];
                if (has_msg_q) begin
                    state_d = MSG_WAIT;
                end else begin
                    s_d[319:256] = s_q[319:256] ^ PAD_BIT;
                    go_final     = 1'b1;
                end
            end
            MSG_WAIT: begin
                if (msg_valid) begin
                    s_d[319:256] = x0_msg;
                    ct_valid_d   = 1'b1;
                    ct_data_d    = x0_msg & keep_mask(n_msg);
                    ct_bytes_d   = n_msg;
                    ct_last_d    = msg_last;
                    last_d       = msg_last;
                    if (msg_last && n_msg != 4'd8) begin
                        go_final = 1'b1;
                    end else begin
                        perm_start_d  = 1'b1;
                        perm_rounds_d = 4'd6;
                        state_d       = MSG_PERM;
                    end
                end
            end
            MSG_PERM: begin
                if (perm_done) begin
                    s_d     = perm_state_out;
                    state_d = last_q ? MSG_PAD : MSG_WAIT;
                end
            end
            MSG_PAD: begin
                s_d[319:256] = s_q[319:256] ^ PAD_BIT;
                go_final     = 1'b1;
            end
            FINAL: begin
                if (perm_done) begin
                    tag_d       = perm_state_out[127:0] ^ key_q;
                    tag_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every path into finalisation mixes the key into x1/x2 and launches p12.
        if (go_final) begin
            s_d[255:128]  = s_d[255:128] ^ key_q;
            perm_start_d  = 1'b1;
            perm_rounds_d = 4'd12;
            state_d       = FINAL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            s_q           <= '0;
            key_q         <= '0;
            has_ad_q      <= 1'b0;
            has_msg_q     <= 1'b0;
            last_q        <= 1'b0;
            full_q        <= 1'b0;
            perm_start_q  <= 1'b0;
            perm_rounds_q <= '0;
            ct_valid_q    <= 1'b0;
            ct_data_q     <= '0;
            ct_bytes_q    <= '0;
            ct_last_q     <= 1'b0;
            tag_q         <= '0;
            tag_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_q           <= s_d;
            key_q         <= key_d;
            has_ad_q      <= has_ad_d;
            has_msg_q     <= has_msg_d;
            last_q        <= last_d;
            full_q        <= full_d;
            perm_start_q  <= perm_start_d;
            perm_rounds_q <= perm_rounds_d;
            ct_valid_q    <= ct_valid_d;
            ct_data_q     <= ct_data_d;
            ct_bytes_q    <= ct_bytes_d;
            ct_last_q     <= ct_last_d;
            tag_q         <= tag_d;
            tag_valid_q   <= tag_valid_d;
        end
    end

    // S only moves on perm_done inside wait states, so it doubles as the engine input.
    assign perm_state_in = s_q;
    assign perm_rounds   = perm_rounds_q;
    assign perm_start    = perm_start_q;
    assign busy          = (state_q != IDLE);
    assign ad_ready      = (state_q == AD_WAIT);
    assign msg_ready     = (state_q == MSG_WAIT);
    assign ct_valid      = ct_valid_q;
    assign ct_data       = ct_data_q;
    assign ct_bytes      = ct_bytes_q;
    assign ct_last       = ct_last_q;
    assign tag           = tag_q;
    assign tag_valid     = tag_valid_q;

endmodule

// File: tb/tb_ascon_aead_ctrl.sv
// tb/tb_ascon_aead_ctrl.sv - directed bench for ascon_aead_ctrl with a behavioural Ascon permutation engine
module tb_ascon_aead_ctrl;

    localparam logic [63:0]  IV      = 64'h80400C0600000000;
    localparam logic [63:0]  PADC    = 64'h8000_0000_0000_0000;
    localparam logic [127:0] K0      = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] K1      = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] K2      = 128'hDEADBEEF0123456789ABCDEFFEDCBA98;
    localparam logic [127:0] N1      = 128'h112233445566778899AABBCCDDEEFF00;
    localparam logic [127:0] N2      = 128'hA5A5A5A55A5A5A5A0F1E2D3C4B5A6978;
    localparam logic [127:0] TAG_KAT = 128'hE355159F292911F794CB1432A0103A8A;

    logic         clk, rst_n, start;
    logic [127:0] key, nonce;
    logic         has_ad, has_msg;
    logic         ad_valid, ad_ready, ad_last;
    logic [63:0]  ad_data;
    logic [3:0]   ad_bytes;
    logic         msg_valid, msg_ready, msg_last;
    logic [63:0]  msg_data;
    logic [3:0]   msg_bytes;
    logic         ct_valid, ct_last;
    logic [63:0]  ct_data;
    logic [3:0]   ct_bytes;
    logic [127:0] tag;
    logic         tag_valid, busy;
    logic [319:0] perm_state_in, perm_state_out;
    logic [3:0]   perm_rounds;
    logic         perm_start, perm_done;

    int vectors = 0;
    int miscompares = 0;

    logic         hold_done;
    int           ps_cnt = 0, ct_cnt = 0, tv_cnt = 0, ar_cyc = 0, proto_err = 0;
    int           ps0, ct0, tv0, ar0;
    logic [63:0]  rlog = '0;
    logic [68:0]  ct_cur = '0, ct_prev = '0;
    logic [127:0] etag;
    logic [63:0]  ec0, ec1;

    ascon_aead_ctrl #(.IV(IV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .nonce(nonce),
        .has_ad(has_ad), .has_msg(has_msg),
        .ad_valid(ad_valid), .ad_ready(ad_ready), .ad_data(ad_data),
        .ad_last(ad_last), .ad_bytes(ad_bytes),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
        .msg_last(msg_last), .msg_bytes(msg_bytes),
        .ct_valid(ct_valid), .ct_data(ct_data), .ct_bytes(ct_bytes), .ct_last(ct_last),
        .tag(tag), .tag_valid(tag_valid), .busy(busy),
        .perm_state_in(perm_state_in), .perm_rounds(perm_rounds), .perm_start(perm_start),
        .perm_state_out(perm_state_out), .perm_done(perm_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_p(input logic [319:0] s, input logic [3:0] rounds);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        for (int r = 12 - int'(rounds); r < 12; r++) begin
            x2 = x2 ^ {56'd0, 4'(15 - r), 4'(r)};
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 ^= ror(x0, 19) ^ ror(x0, 28);
            x1 ^= ror(x1, 61) ^ ror(x1, 39);
            x2 ^= ror(x2, 1)  ^ ror(x2, 6);
            x3 ^= ror(x3, 10) ^ ror(x3, 17);
            x4 ^= ror(x4, 7)  ^ ror(x4, 41);
        end
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [63:0] padr(input logic [63:0] d, input int n);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            if (b < n)       r[63-8*b -: 8] = d[63-8*b -: 8];
            else if (b == n) r[63-8*b -: 8] = 8'h80;
        end
        return r;
    endfunction

    function automatic logic [63:0] keepr(input logic [63:0] d, input int n);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < n; b++) r[63-8*b -: 8] = d[63-8*b -: 8];
        return r;
    endfunction

    // Reference Ascon-128 encryption: up to one AD word, up to two message words.
    function automatic void aead_ref(input logic [127:0] k, input logic [127:0] n,
                                     input bit had, input logic [63:0] adw, input int adn,
                                     input int nm, input logic [63:0] m0, input logic [63:0] m1,
                                     input int mn, output logic [127:0] tg,
                                     output logic [63:0] c0, output logic [63:0] c1);
        logic [319:0] s;
        logic [63:0]  lw, cl;
        s = ascon_p({IV, k, n}, 4'd12) ^ {192'd0, k};
        if (had) begin
            s[319:256] ^= padr(adw, adn);
            s = ascon_p(s, 4'd6);
            if (adn == 8) begin
                s[319:256] ^= PADC;
                s = ascon_p(s, 4'd6);
            end
        end
        s[0] = ~s[0];
        c0 = '0; c1 = '0;
        if (nm == 0) begin
            s[319:256] ^= PADC;
        end else begin
            lw = m0;
            if (nm == 2) begin
                s[319:256] ^= m0;
                c0 = s[319:256];
                s = ascon_p(s, 4'd6);
                lw = m1;
            end
            s[319:256] ^= padr(lw, mn);
            cl = keepr(s[319:256], mn);
            if (mn == 8) begin
                s = ascon_p(s, 4'd6);
                s[319:256] ^= PADC;
            end
            if (nm == 2) c1 = cl; else c0 = cl;
        end
        s[255:128] ^= k;
        s = ascon_p(s, 4'd12);
        tg = s[127:0] ^ k;
    endfunction

    // Permutation engine and output monitor, acting just after each rising edge.
    int           pe_cnt = 0;
    bit           pe_busy = 0;
    logic [319:0] pe_state = '0;
    logic [3:0]   pe_rounds = '0;
    initial begin
        perm_done = 1'b0;
        perm_state_out = '0;
        forever begin
            @(posedge clk);
            #1;
            perm_done = 1'b0;
            if (!rst_n) begin
                pe_busy = 0;
            end else begin
                if (pe_busy && !hold_done) begin
                    if (pe_cnt == 0) begin
                        perm_done = 1'b1;
                        perm_state_out = ascon_p(pe_state, pe_rounds);
                        pe_busy = 0;
                    end else begin
                        pe_cnt--;
                    end
                end
                if (pe_busy && (perm_state_in !== pe_state || perm_rounds !== pe_rounds))
                    proto_err++;
                if (perm_start) begin
                    if (pe_busy) proto_err++;
                    ps_cnt++;
                    rlog = {rlog[59:0], perm_rounds};
                    pe_busy = 1;
                    pe_cnt = 2;
                    pe_state = perm_state_in;
                    pe_rounds = perm_rounds;
                end
            end
            if (ad_ready) ar_cyc++;
            if (ct_valid) begin
                ct_cnt++;
                ct_prev = ct_cur;
                ct_cur = {ct_last, ct_bytes, ct_data};
            end
            if (tag_valid) tv_cnt++;
        end
    end

    task automatic check(input string nm, input logic [319:0] obs, input logic [319:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_busy"}, busy, 0);
        check({p, "_ad_ready"}, ad_ready, 0);
        check({p, "_msg_ready"}, msg_ready, 0);
        check({p, "_ct_valid"}, ct_valid, 0);
        check({p, "_ct_last"}, ct_last, 0);
        check({p, "_tag_valid"}, tag_valid, 0);
        check({p, "_perm_start"}, perm_start, 0);
        check({p, "_ct_data"}, ct_data, 0);
        check({p, "_ct_bytes"}, ct_bytes, 0);
        check({p, "_tag"}, tag, 0);
        check({p, "_perm_state_in"}, perm_state_in, 0);
        check({p, "_perm_rounds"}, perm_rounds, 0);
    endtask

    task automatic snap();
        ps0 = ps_cnt; ct0 = ct_cnt; tv0 = tv_cnt; ar0 = ar_cyc;
    endtask

    task automatic run_start(input logic [127:0] k, input logic [127:0] n,
                             input logic ha, input logic hm);
        key = k; nonce = n; has_ad = ha; has_msg = hm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 600; i++) begin
            if (busy === 1'b0) break;
            @(negedge clk);
        end
        check({nm, "_idle_timeout"}, busy, 0);
    endtask

    task automatic send_ad(input logic [63:0] d, input logic [3:0] b, input logic l);
        ad_data = d; ad_bytes = b; ad_last = l; ad_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (ad_ready === 1'b1) break;
            @(negedge clk);
        end
        check("ad_ready_timeout", ad_ready, 1);
        @(negedge clk);
        ad_valid = 1'b0;
    endtask

    task automatic send_msg(input logic [63:0] d, input logic [3:0] b, input logic l);
        msg_data = d; msg_bytes = b; msg_last = l; msg_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (msg_ready === 1'b1) break;
            @(negedge clk);
        end
        check("msg_ready_timeout", msg_ready, 1);
        @(negedge clk);
        msg_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; key = '0; nonce = '0; has_ad = 1'b0; has_msg = 1'b0;
        ad_valid = 1'b0; ad_data = '0; ad_last = 1'b0; ad_bytes = '0;
        msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0; msg_bytes = '0;
        hold_done = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_reset("rst");

        // Known-answer: empty AD, empty message
        snap();
        run_start(K0, K0, 1'b0, 1'b0);
        check("kat_busy", busy, 1);
        check("kat_pstart", perm_start, 1);
        check("kat_prounds", perm_rounds, 12);
        check("kat_pstate", perm_state_in, {IV, K0, K0});
        wait_idle("kat");
        check("kat_tag", tag, TAG_KAT);
        check("kat_tv_cnt", tv_cnt - tv0, 1);
        check("kat_ps_cnt", ps_cnt - ps0, 2);
        check("kat_rounds", rlog[7:0], 8'hCC);
        check("kat_ct_cnt", ct_cnt - ct0, 0);
        check("kat_tag_valid_low", tag_valid, 0);

        // One full AD word, empty message
        snap();
        ad_data = 64'h0001020304050607; ad_bytes = 4'd8; ad_last = 1'b1; ad_valid = 1'b1;
        run_start(K1, N1, 1'b1, 1'b0);
        wait_idle("ad8");
        ad_valid = 1'b0;
        aead_ref(K1, N1, 1, 64'h0001020304050607, 8, 0, 0, 0, 8, etag, ec0, ec1);
        check("ad8_rounds", rlog[15:0], 16'hC66C);
        check("ad8_ps_cnt", ps_cnt - ps0, 4);
        check("ad8_ready_cyc", ar_cyc - ar0, 1);
        check("ad8_tag", tag, etag);
        check("ad8_ct_cnt", ct_cnt - ct0, 0);

        // Empty AD, 3-byte message
        snap();
        msg_data = 64'hAABBCC0000000000; msg_bytes = 4'd3; msg_last = 1'b1; msg_valid = 1'b1;
        run_start(K0, K0, 1'b0, 1'b1);
        wait_idle("m3");
        msg_valid = 1'b0;
        aead_ref(K0, K0, 0, 0, 0, 1, 64'hAABBCC0000000000, 0, 3, etag, ec0, ec1);
        check("m3_ct_cnt", ct_cnt - ct0, 1);
        check("m3_ct_bytes", ct_cur[67:64], 3);
        check("m3_ct_last", ct_cur[68], 1);
        check("m3_ct_low_zero", ct_cur[39:0], 0);
        check("m3_ct_data", ct_cur[63:0], ec0);
        check("m3_rounds", rlog[7:0], 8'hCC);
        check("m3_ps_cnt", ps_cnt - ps0, 2);
        check("m3_tag", tag, etag);

        // ad_bytes=0 on last (full), non-last msg with bytes=3 (full), full last msg
        snap();
        run_start(K1, N1, 1'b1, 1'b1);
        send_ad(64'h1122334455667788, 4'd0, 1'b1);
        send_msg(64'h0123456789ABCDEF, 4'd3, 1'b0);
        send_msg(64'hFEDCBA9876543210, 4'd8, 1'b1);
        wait_idle("mw");
        aead_ref(K1, N1, 1, 64'h1122334455667788, 8, 2,
                 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 8, etag, ec0, ec1);
        check("mw_rounds", rlog[23:0], 24'hC6666C);
        check("mw_ps_cnt", ps_cnt - ps0, 6);
        check("mw_ct_cnt", ct_cnt - ct0, 2);
        check("mw_ct0", ct_prev, {1'b0, 4'd8, ec0});
        check("mw_ct1", ct_cur, {1'b1, 4'd8, ec1});
        check("mw_tag", tag, etag);

        // start during AD phase ignored; msg_valid held early; msg_bytes=9 means 8
        snap();
        msg_data = 64'h5555AAAA0F0F3C3C; msg_bytes = 4'd9; msg_last = 1'b1; msg_valid = 1'b1;
        run_start(K2, N2, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        check("rs_ad_wait", ad_ready, 1);
        check("rs_msg_ready_early", msg_ready, 0);
        key = K0; nonce = K0; has_ad = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rs_no_restart", ps_cnt - ps0, 1);
        check("rs_msg_ready_still", msg_ready, 0);
        send_ad(64'hCAFEBABE12000000, 4'd5, 1'b1);
        wait_idle("rs");
        msg_valid = 1'b0;
        aead_ref(K2, N2, 1, 64'hCAFEBABE12000000, 5, 1, 64'h5555AAAA0F0F3C3C, 0, 8,
                 etag, ec0, ec1);
        check("rs_rounds", rlog[15:0], 16'hC66C);
        check("rs_ct", ct_cur, {1'b1, 4'd8, ec0});
        check("rs_ct_cnt", ct_cnt - ct0, 1);
        check("rs_tag", tag, etag);

        // perm_done withheld 20 cycles in INIT
        snap();
        hold_done = 1'b1;
        ad_data = 64'h9988770000000000; ad_bytes = 4'd3; ad_last = 1'b1; ad_valid = 1'b1;
        run_start(K1, N2, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("hold_ps_cnt", ps_cnt - ps0, 1);
        check("hold_no_ready", ar_cyc - ar0, 0);
        check("hold_busy", busy, 1);
        hold_done = 1'b0;
        wait_idle("hold");
        ad_valid = 1'b0;
        aead_ref(K1, N2, 1, 64'h9988770000000000, 3, 0, 0, 0, 8, etag, ec0, ec1);
        check("hold_rounds", rlog[11:0], 12'hC6C);
        check("hold_ps_total", ps_cnt - ps0, 3);
        check("hold_tag", tag, etag);

        // Reset mid-AD, then the known-answer run again
        snap();
        run_start(K0, K0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("mr_in_ad", ad_ready, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset("mr");
        repeat (6) @(negedge clk);
        check("mr_no_tv", tv_cnt - tv0, 0);
        check("mr_no_ct", ct_cnt - ct0, 0);
        snap();
        run_start(K0, K0, 1'b0, 1'b0);
        wait_idle("mr_kat");
        check("mr_kat_tag", tag, TAG_KAT);
        check("mr_kat_ps_cnt", ps_cnt - ps0, 2);
        check("mr_kat_tv_cnt", tv_cnt - tv0, 1);

        check("perm_protocol", proto_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ascon_aead_ctrl.md
ASCON_AEAD_CTRL -- requirements
Module: ascon_aead_ctrl

Interface
REQ-001 SHALL have parameter IV, default 64'h80400C0600000000, the Ascon-128 initial value placed in x0.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  begin an encryption; accepted only when busy=0.
REQ-005 SHALL have ports key, nonce  input  128 each  latched on accepted start.
REQ-006 SHALL have ports has_ad, has_msg  input  1 each  latched on accepted start; 0 means empty AD or empty message.
REQ-007 SHALL have ports ad_valid/ad_ready (in/out, 1), ad_data (in, 64), ad_last (in, 1), ad_bytes (in, 4)  AD word stream.
REQ-008 SHALL have ports msg_valid/msg_ready (in/out, 1), msg_data (in, 64), msg_last (in, 1), msg_bytes (in, 4)  plaintext word stream.
REQ-009 SHALL have ports ct_valid (out, 1), ct_data (out, 64), ct_bytes (out, 4), ct_last (out, 1)  ciphertext; no backpressure.
REQ-010 SHALL have ports tag (out, 128), tag_valid (out, 1), busy (out, 1).
REQ-011 SHALL have ports perm_state_in (out, 320), perm_rounds (out, 4), perm_start (out, 1), perm_state_out (in, 320), perm_done (in, 1)  permutation-engine link; x0 is bits [319:256].

Function
REQ-012 SHALL use FSM states IDLE, INIT, AD_WAIT, AD_PERM, AD_PAD, DOMSEP, MSG_WAIT, MSG_PERM, MSG_PAD, FINAL, DONE.
REQ-013 On start in IDLE: S = IV||key||nonce; pulse perm_start one cycle with perm_rounds=12; enter INIT; busy=1 from the next cycle.
REQ-014 perm_start SHALL be a one-cycle pulse, never reasserted before perm_done of the preceding call; perm_state_in and perm_rounds held stable from pulse until perm_done.
REQ-015 INIT on perm_done: S = perm_state_out ^ (0^192||key); go to AD_WAIT if has_ad, else DOMSEP.
REQ-016 ad_ready SHALL be 1 only in AD_WAIT; msg_ready only in MSG_WAIT; valid without ready has no effect.
REQ-017 pad(d,n): the n most-significant bytes of d, byte n (counted from MSB) = 0x80, remaining bytes 0; n=8 gives d unchanged.
REQ-018 n = ad_bytes/msg_bytes only when the corresponding *_last=1; non-last words are always n=8; last-word values 0 or >8 treated as 8.
REQ-019 AD handshake: x0 ^= pad(ad_data,n); start p6 (AD_PERM); on perm_done S=perm_state_out; if not last -> AD_WAIT; if last and n<8 -> DOMSEP; if last and n=8 -> x0 ^= 0x80<<56, p6 (AD_PAD), then DOMSEP.
REQ-020 DOMSEP (one cycle): x4 ^= 1; go to MSG_WAIT if has_msg, else x0 ^= 0x80<<56 and go to FINAL.
REQ-021 MSG handshake: x0' = x0 ^ pad(msg_data,n); next cycle ct_valid=1 one cycle, ct_data = x0' with the lower 8-n bytes forced to 0, ct_bytes=n, ct_last=msg_last.
REQ-022 After MSG handshake: not last -> p6 (MSG_PERM), then MSG_WAIT; last and n<8 -> FINAL; last and n=8 -> p6, then x0 ^= 0x80<<56 (MSG_PAD, no ciphertext), then FINAL.
REQ-023 FINAL: S ^= 0^64||key||0^128; start p12; on perm_done tag = perm_state_out[127:0] ^ key; enter DONE.
REQ-024 DONE (one cycle): tag_valid=1 one cycle; tag held until next accepted start; busy=0 next cycle; return to IDLE.
REQ-025 start while busy=1 SHALL be ignored without side effects; perm_done outside a wait state ignored.
REQ-026 Block SHALL stall indefinitely in any wait state until perm_done; no timeout.

Reset
REQ-027 rst_n=0 at a clock edge: FSM=IDLE; busy, ad_ready, msg_ready, ct_valid, ct_last, tag_valid, perm_start = 0; ct_data, ct_bytes, tag, perm_state_in, perm_rounds, S, latched key/nonce = 0.
REQ-028 Reset mid-operation SHALL abort with no further ct_valid/tag_valid; integrator resets the permutation engine with the same rst_n.

Verification
REQ-029 key=nonce=000102..0F, has_ad=0, has_msg=0 -> tag=E355159F292911F794CB1432A0103A8A; exactly two perm_start pulses, both rounds=12.
REQ-030 has_ad=1, one AD word n=8 last, has_msg=0 -> perm_rounds sequence 12,6,6,12; ad_ready high exactly one handshake.
REQ-031 has_ad=0, msg_data=AABBCC0000000000 msg_bytes=3 last -> one ct_valid, ct_bytes=3, ct_last=1, ct_data[39:0]=0; perm sequence 12,12.
REQ-032 start pulsed during AD phase and msg_valid held 1 -> no restart, msg_ready stays 0 until MSG_WAIT.
REQ-033 perm_done withheld 20 cycles in INIT -> no ready, no perm_start pulse; resumes on perm_done.
REQ-034 rst_n=0 for one cycle mid AD -> next cycle all outputs per REQ-027; subsequent start runs REQ-029 correctly.
